// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_pkg
// Description : Shared constants for the MCPU core: field widths, memory
//               depth and the 4-bit opcode map.
// Revision    : 1.0 - initial release
// ============================================================================
package mcpu_pkg;

    localparam int C_WORD_SIZE    = 16;
    localparam int C_OPCODE_SIZE  = 4;
    localparam int C_OPERAND_SIZE = 4;
    localparam int C_MEM_DEPTH    = 256;

    typedef logic [C_OPCODE_SIZE-1:0] opcode_t;

    localparam opcode_t C_OP_AND   = 4'd0;
    localparam opcode_t C_OP_OR    = 4'd1;
    localparam opcode_t C_OP_XOR   = 4'd2;
    localparam opcode_t C_OP_NOT   = 4'd3;
    localparam opcode_t C_OP_ADD   = 4'd4;
    localparam opcode_t C_OP_SUB   = 4'd5;
    localparam opcode_t C_OP_LSL   = 4'd6;
    localparam opcode_t C_OP_LSR   = 4'd7;
    localparam opcode_t C_OP_MOV   = 4'd8;
    localparam opcode_t C_OP_LI    = 4'd9;
    localparam opcode_t C_OP_LOAD  = 4'd10;
    localparam opcode_t C_OP_STORE = 4'd11;
    localparam opcode_t C_OP_BNZ   = 4'd12;
    localparam opcode_t C_OP_BZ    = 4'd13;
    localparam opcode_t C_OP_JMP   = 4'd14;
    localparam opcode_t C_OP_HALT  = 4'd15;

endpackage
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
// Module      : ram
// Description : Unified code/data memory. Asynchronous fetch and data read
//               ports, synchronous write on the data address. Not reset.
// Ports       : clock       - write clock
//               fa_i/fd_o   - fetch address / instruction word
//               da_i/dd_o   - data address / load data
//               we_i, wd_i  - store enable / store data (written at da_i)
// Revision    : 1.0 - initial release
// ============================================================================
module ram
    import mcpu_pkg::*;
#(
    parameter int WIDTH = C_WORD_SIZE,
    parameter int DEPTH = C_MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [AW-1:0]    fa_i,
    output logic [WIDTH-1:0] fd_o,
    input  logic [AW-1:0]    da_i,
    output logic [WIDTH-1:0] dd_o,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wd_i
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    assign fd_o = mem[fa_i];
    assign dd_o = mem[da_i];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[da_i] <= wd_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : General register file, three asynchronous read ports and
//               one synchronous write port. Not reset, so contents preloaded
//               before reset release survive.
// Ports       : clock         - write clock
//               ra1_i/rd1_o   - read port 1 (rs1)
//               ra2_i/rd2_o   - read port 2 (rs2)
//               ra3_i/rd3_o   - read port 3 (rd: store data / branch test)
//               we_i,wa_i,wd_i- write enable, address, data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import mcpu_pkg::*;
#(
    parameter int WIDTH = C_WORD_SIZE,
    parameter int AW    = C_OPERAND_SIZE
) (
    input  logic             clock,
    input  logic [AW-1:0]    ra1_i,
    input  logic [AW-1:0]    ra2_i,
    input  logic [AW-1:0]    ra3_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o,
    output logic [WIDTH-1:0] rd3_o,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i
);

    logic [WIDTH-1:0] R [0:(2**AW)-1];

    assign rd1_o = R[ra1_i];
    assign rd2_o = R[ra2_i];
    assign rd3_o = R[ra3_i];

    always_ff @(posedge clock) begin
        if (we_i) begin
            R[wa_i] <= wd_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcpu.sv
`default_nettype none
// ============================================================================
// Module      : mcpu
// Description : Single-cycle 16-bit load/store CPU. Each rising edge retires
//               one instruction fetched from the unified memory.
//               R-type {op, rd, rs1, rs2}, B-type {op, rd, imm8}.
// Ports       : clock - single clock, all state updates on the rising edge
//               reset - asynchronous, active-low (0 = held in reset)
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu
    import mcpu_pkg::*;
#(
    parameter int WORD_SIZE    = C_WORD_SIZE,
    parameter int OPCODE_SIZE  = C_OPCODE_SIZE,
    parameter int OPERAND_SIZE = C_OPERAND_SIZE,
    parameter int MEM_DEPTH    = C_MEM_DEPTH,
    parameter logic [OPCODE_SIZE-1:0] OP_AND   = C_OP_AND,
    parameter logic [OPCODE_SIZE-1:0] OP_OR    = C_OP_OR,
    parameter logic [OPCODE_SIZE-1:0] OP_XOR   = C_OP_XOR,
    parameter logic [OPCODE_SIZE-1:0] OP_NOT   = C_OP_NOT,
    parameter logic [OPCODE_SIZE-1:0] OP_ADD   = C_OP_ADD,
    parameter logic [OPCODE_SIZE-1:0] OP_SUB   = C_OP_SUB,
    parameter logic [OPCODE_SIZE-1:0] OP_LSL   = C_OP_LSL,
    parameter logic [OPCODE_SIZE-1:0] OP_LSR   = C_OP_LSR,
    parameter logic [OPCODE_SIZE-1:0] OP_MOV   = C_OP_MOV,
    parameter logic [OPCODE_SIZE-1:0] OP_LI    = C_OP_LI,
    parameter logic [OPCODE_SIZE-1:0] OP_LOAD  = C_OP_LOAD,
    parameter logic [OPCODE_SIZE-1:0] OP_STORE = C_OP_STORE,
    parameter logic [OPCODE_SIZE-1:0] OP_BNZ   = C_OP_BNZ,
    parameter logic [OPCODE_SIZE-1:0] OP_BZ    = C_OP_BZ,
    parameter logic [OPCODE_SIZE-1:0] OP_JMP   = C_OP_JMP,
    parameter logic [OPCODE_SIZE-1:0] OP_HALT  = C_OP_HALT
) (
    input  logic clock,
    input  logic reset
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    // ---- architectural state ----
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;

    // ---- decode ----
    logic [WORD_SIZE-1:0]    w_instr;
    logic [OPCODE_SIZE-1:0]  w_op;
    logic [OPERAND_SIZE-1:0] w_rd, w_rs1, w_rs2;
    logic [ADDR_W-1:0]       w_imm;

    assign w_op  = w_instr[WORD_SIZE-1 -: OPCODE_SIZE];
    assign w_rd  = w_instr[WORD_SIZE-OPCODE_SIZE-1 -: OPERAND_SIZE];
    assign w_rs1 = w_instr[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign w_rs2 = w_instr[OPERAND_SIZE-1:0];
    assign w_imm = w_instr[ADDR_W-1:0];

    // ---- datapath wires ----
    logic [WORD_SIZE-1:0] w_a, w_b, w_rdval, w_load;
    logic                 w_rf_we, w_mem_we;
    logic [WORD_SIZE-1:0] w_rf_wd;

    regfile #(
        .WIDTH (WORD_SIZE),
        .AW    (OPERAND_SIZE)
    ) regfileinst (
        .clock (clock),
        .ra1_i (w_rs1),
        .ra2_i (w_rs2),
        .ra3_i (w_rd),
        .rd1_o (w_a),
        .rd2_o (w_b),
        .rd3_o (w_rdval),
        .we_i  (w_rf_we),
        .wa_i  (w_rd),
        .wd_i  (w_rf_wd)
    );

    ram #(
        .WIDTH (WORD_SIZE),
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_W)
    ) raminst (
        .clock (clock),
        .fa_i  (pc_q),
        .fd_o  (w_instr),
        .da_i  (w_a[ADDR_W-1:0]),
        .dd_o  (w_load),
        .we_i  (w_mem_we),
        .wd_i  (w_rdval)
    );

    // ---- execute / next PC ----
    // Writes are gated by reset as well as halt so that a core held in reset
    // leaves preloaded registers and memory untouched across clock edges.
    always_comb begin
        pc_d     = pc_q + 1'b1;
        halted_d = halted_q;
        w_rf_we  = 1'b0;
        w_rf_wd  = '0;
        w_mem_we = 1'b0;
        if (!reset || halted_q) begin
            pc_d = pc_q;
        end else begin
            case (w_op)
                OP_AND:   begin w_rf_we = 1'b1; w_rf_wd = w_a & w_b; end
                OP_OR:    begin w_rf_we = 1'b1; w_rf_wd = w_a | w_b; end
                OP_XOR:   begin w_rf_we = 1'b1; w_rf_wd = w_a ^ w_b; end
                OP_NOT:   begin w_rf_we = 1'b1; w_rf_wd = ~w_a; end
                OP_ADD:   begin w_rf_we = 1'b1; w_rf_wd = w_a + w_b; end
                OP_SUB:   begin w_rf_we = 1'b1; w_rf_wd = w_a - w_b; end
                // The full 16-bit b is the shift amount; >= WORD_SIZE yields 0.
                OP_LSL:   begin w_rf_we = 1'b1; w_rf_wd = w_a << w_b; end
                OP_LSR:   begin w_rf_we = 1'b1; w_rf_wd = w_a >> w_b; end
                OP_MOV:   begin w_rf_we = 1'b1; w_rf_wd = w_a; end
                OP_LI:    begin
                    w_rf_we = 1'b1;
                    w_rf_wd = {{(WORD_SIZE-ADDR_W){1'b0}}, w_imm};
                end
                OP_LOAD:  begin w_rf_we = 1'b1; w_rf_wd = w_load; end
                OP_STORE: w_mem_we = 1'b1;
                OP_BNZ:   if (w_rdval != '0) pc_d = w_imm;
                OP_BZ:    if (w_rdval == '0) pc_d = w_imm;
                OP_JMP:   pc_d = w_imm;
                OP_HALT:  begin halted_d = 1'b1; pc_d = pc_q; end
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcpu
// Description : Scoreboard bench for mcpu. An instruction-level interpreter
//               predicts PC after each clock and the final register, memory
//               and halt state; a monitor compares at each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu;

    logic clock;
    logic reset;

    mcpu cpu (
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // kind: 0 = PC after one clock, 1 = register, 2 = memory word, 3 = halted
    typedef struct {
        int          kind;
        int          idx;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference machine state
    logic [15:0] mr [16];
    logic [15:0] mm [256];
    int          mpc;
    bit          mhalt;

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // ---- monitor ----
    always @(negedge clock) begin
        if (reset === 1'b1 && sbq.size() > 0) begin
            if (sbq[0].kind == 0) begin
                mon_e = sbq.pop_front();
                check("pc", 0, 16'(cpu.pc_q), mon_e.val);
            end
            while (sbq.size() > 0 && sbq[0].kind != 0) begin
                mon_e = sbq.pop_front();
                case (mon_e.kind)
                    1:       check("reg", mon_e.idx, cpu.regfileinst.R[mon_e.idx], mon_e.val);
                    2:       check("mem", mon_e.idx, cpu.raminst.mem[mon_e.idx], mon_e.val);
                    default: check("halted", 0, 16'(cpu.halted_q), mon_e.val);
                endcase
            end
        end
    end

    // ---- instruction encoders ----
    function automatic logic [15:0] ir(int op, int rd, int s1, int s2);
        return {4'(op), 4'(rd), 4'(s1), 4'(s2)};
    endfunction

    function automatic logic [15:0] ib(int op, int rd, int imm);
        return {4'(op), 4'(rd), 8'(imm)};
    endfunction

    // ---- reference interpreter: one instruction per call ----
    function automatic void mstep();
        logic [15:0] ins;
        int op, rd, s1, s2, imm, nxt;
        longint a, b;
        if (mhalt) return;
        ins = mm[mpc];
        op  = int'(ins) / 4096;
        rd  = (int'(ins) / 256) % 16;
        s1  = (int'(ins) / 16) % 16;
        s2  = int'(ins) % 16;
        imm = int'(ins) % 256;
        a   = longint'(mr[s1]);
        b   = longint'(mr[s2]);
        nxt = (mpc + 1) % 256;
        case (op)
            0:  mr[rd] = mr[s1] & mr[s2];
            1:  mr[rd] = mr[s1] | mr[s2];
            2:  mr[rd] = mr[s1] ^ mr[s2];
            3:  mr[rd] = ~mr[s1];
            4:  mr[rd] = 16'((a + b) % 65536);
            5:  mr[rd] = 16'((a - b + 65536) % 65536);
            6:  mr[rd] = (b >= 16) ? 16'h0 : 16'((a * (longint'(1) << b)) % 65536);
            7:  mr[rd] = (b >= 16) ? 16'h0 : 16'(a / (longint'(1) << b));
            8:  mr[rd] = mr[s1];
            9:  mr[rd] = 16'(imm);
            10: mr[rd] = mm[int'(a % 256)];
            11: mm[int'(a % 256)] = mr[rd];
            12: if (mr[rd] != 0) nxt = imm;
            13: if (mr[rd] == 0) nxt = imm;
            14: nxt = imm;
            default: begin mhalt = 1'b1; nxt = mpc; end
        endcase
        mpc = nxt;
    endfunction

    // ---- stimulus helpers ----
    task automatic setr(input int i, input logic [15:0] v);
        cpu.regfileinst.R[i] <= v;
        mr[i] = v;
    endtask

    task automatic setm(input int i, input logic [15:0] v);
        cpu.raminst.mem[i] <= v;
        mm[i] = v;
    endtask

    task automatic init_state();
        for (int i = 0; i < 16; i++) setr(i, 16'h0000);
        for (int i = 0; i < 256; i++) setm(i, 16'hF000);
        #1;
    endtask

    task automatic enter_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        mpc   = 0;
        mhalt = 1'b0;
    endtask

    task automatic push(input int kind, input int idx, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sbq.push_back(e);
    endtask

    // Predict k clocks of execution and the final state.
    task automatic expect_run(input int k, input bit full_mem);
        for (int i = 0; i < k; i++) begin
            mstep();
            push(0, 0, 16'(mpc));
        end
        for (int i = 0; i < 16; i++) push(1, i, mr[i]);
        push(3, 0, 16'(mhalt));
        if (full_mem) begin
            for (int i = 0; i < 256; i++) push(2, i, mm[i]);
        end
    endtask

    // Release reset and run exactly k clocks; the queue must then be empty.
    task automatic go(input int k);
        @(negedge clock);
        #1 reset = 1'b1;
        repeat (k) @(negedge clock);
        #1;
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        mpc   = 0;
        mhalt = 1'b0;
        repeat (2) @(negedge clock);

        // reset state
        #1;
        check("reset_pc", 0, 16'(cpu.pc_q), 16'h0000);
        check("reset_halted", 0, 16'(cpu.halted_q), 16'h0000);

        // XOR / ADD / SUB then HALT; one extra clock shows PC frozen at 3
        init_state();
        setr(0, 16'd5); setr(1, 16'd3);
        setm(0, ir(2, 2, 0, 1)); setm(1, ir(4, 3, 0, 1));
        setm(2, ir(5, 4, 0, 1)); setm(3, ir(15, 0, 0, 0));
        expect_run(5, 1'b0);
        push(1, 2, 16'd6); push(1, 3, 16'd8); push(1, 4, 16'd2); push(3, 0, 16'd1);
        go(5);
        enter_reset();

        // shifts, including shift amount of 16
        init_state();
        setr(0, 16'd4488); setr(1, 16'd1);
        setm(0, ir(6, 2, 0, 1)); setm(1, ir(7, 3, 0, 1));
        setm(2, ib(9, 1, 16));
        setm(3, ir(6, 4, 0, 1)); setm(4, ir(7, 5, 0, 1));
        expect_run(6, 1'b0);
        push(1, 2, 16'd8976); push(1, 3, 16'd2244); push(1, 4, 16'd0); push(1, 5, 16'd0);
        go(6);
        enter_reset();

        // countdown loop
        init_state();
        setr(0, 16'd3); setr(1, 16'd1);
        setm(0, ir(5, 0, 0, 1)); setm(1, ib(12, 0, 0));
        expect_run(7, 1'b0);
        push(1, 0, 16'd0); push(3, 0, 16'd1);
        go(7);
        enter_reset();

        // hailstone from 6
        init_state();
        setr(0, 16'd6); setr(1, 16'd1);
        setm(0, ir(5, 2, 0, 1));  setm(1, ib(13, 2, 10));
        setm(2, ir(0, 2, 0, 1));  setm(3, ib(12, 2, 6));
        setm(4, ir(7, 0, 0, 1));  setm(5, ib(14, 0, 0));
        setm(6, ir(6, 2, 0, 1));  setm(7, ir(4, 0, 0, 2));
        setm(8, ir(4, 0, 0, 1));  setm(9, ib(14, 0, 0));
        expect_run(120, 1'b0);
        push(1, 0, 16'd1); push(3, 0, 16'd1);
        go(120);
        enter_reset();

        // LI / STORE / LOAD
        init_state();
        setm(0, ib(9, 5, 8'h40)); setm(1, ib(9, 6, 8'hAB));
        setm(2, ir(11, 6, 5, 0)); setm(3, ir(10, 7, 5, 0));
        expect_run(5, 1'b1);
        push(2, 64, 16'h00AB); push(1, 7, 16'h00AB);
        go(5);
        enter_reset();

        // PC wrap 255 -> 0
        init_state();
        setm(0, ib(13, 8, 254));
        setm(254, ib(9, 8, 1)); setm(255, ir(8, 9, 8, 0));
        expect_run(5, 1'b0);
        push(1, 9, 16'd1);
        go(5);
        enter_reset();

        // asynchronous reset mid-loop, then restart from mem[0]
        init_state();
        setr(0, 16'd200); setr(1, 16'd1);
        setm(0, ir(5, 0, 0, 1)); setm(1, ib(12, 0, 0));
        expect_run(5, 1'b0);
        go(5);
        #1 reset = 1'b0;
        #1;
        check("async_pc", 0, 16'(cpu.pc_q), 16'h0000);
        check("async_r0", 0, cpu.regfileinst.R[0], 16'd197);
        for (int i = 0; i < 16; i++) check("async_reg", i, cpu.regfileinst.R[i], mr[i]);
        mpc   = 0;
        mhalt = 1'b0;
        expect_run(6, 1'b0);
        push(1, 0, 16'd194);
        go(6);
        enter_reset();

        // randomized straight-line programs (ALU, LI, LOAD, STORE)
        for (int t = 0; t < 5; t++) begin
            init_state();
            for (int i = 0; i < 16; i++) setr(i, 16'($urandom));
            setr(1, 16'($urandom_range(0, 20)));
            for (int i = 21; i < 256; i++) setm(i, 16'($urandom));
            for (int i = 0; i < 20; i++)
                setm(i, ir($urandom_range(0, 11), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15)));
            setm(20, ir(15, 0, 0, 0));
            #1;
            expect_run(24, 1'b1);
            go(24);
            enter_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
